// File: rtl/climate_scheduler.sv
// ============================================================================
// climate_scheduler: hysteresis-based heat/cool sequencer with minimum run and rest times.
// Revision: 1.0
// ============================================================================
`default_nettype none

module climate_scheduler #(
  parameter logic [4:0] HEAT_ON  = 5'd18,
  parameter logic [4:0] HEAT_OFF = 5'd20,
  parameter logic [4:0] COOL_ON  = 5'd22,
  parameter logic [4:0] COOL_OFF = 5'd20,
  parameter int         MIN_ON   = 4,
  parameter int         MIN_OFF  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [4:0] temperature,
  output logic       heating,
  output logic       cooling,
  output logic [1:0] state,
  output logic       lockout
);

  localparam logic [1:0] c_IDLE = 2'b00;
  localparam logic [1:0] c_HEAT = 2'b01;
  localparam logic [1:0] c_COOL = 2'b10;
  localparam logic [1:0] c_REST = 2'b11;

  // Timer values seen on the last cycle of the minimum run / rest windows.
  localparam logic [7:0] c_ON_LAST  = 8'(MIN_ON - 1);
  localparam logic [7:0] c_OFF_LAST = 8'(MIN_OFF - 1);

  logic [1:0] r_state;
  logic [7:0] r_timer;
  logic [1:0] w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (enable && (temperature <= HEAT_ON)) begin
          w_next = c_HEAT;
        end else if (enable && (temperature >= COOL_ON)) begin
          w_next = c_COOL;
        end
      end
      c_HEAT: begin
        if (!enable || ((r_timer >= c_ON_LAST) && (temperature >= HEAT_OFF))) begin
          w_next = c_REST;
        end
      end
      c_COOL: begin
        if (!enable || ((r_timer >= c_ON_LAST) && (temperature <= COOL_OFF))) begin
          w_next = c_REST;
        end
      end
      c_REST: begin
        if (r_timer == c_OFF_LAST) begin
          w_next = c_IDLE;
        end
      end
      default: w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_timer <= 8'd0;
    end else begin
      r_state <= w_next;
      // Timer restarts on every state entry and saturates rather than wraps.
      if (w_next != r_state) begin
        r_timer <= 8'd0;
      end else if (r_timer != 8'hFF) begin
        r_timer <= r_timer + 8'd1;
      end
    end
  end

  assign heating = (r_state == c_HEAT);
  assign cooling = (r_state == c_COOL);
  assign lockout = (r_state == c_REST);
  assign state   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_climate_scheduler.sv
// ============================================================================
// tb_climate_scheduler: directed scenario bench for climate_scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_climate_scheduler;

  // Expected {state, heating, cooling, lockout} per state.
  localparam logic [4:0] c_S_IDLE = 5'b00_0_0_0;
  localparam logic [4:0] c_S_HEAT = 5'b01_1_0_0;
  localparam logic [4:0] c_S_COOL = 5'b10_0_1_0;
  localparam logic [4:0] c_S_REST = 5'b11_0_0_1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [4:0] temperature = 5'd20;
  logic       heating;
  logic       cooling;
  logic [1:0] state;
  logic       lockout;

  int total = 0;
  int bad   = 0;
  bit sweep_on = 1'b0;

  climate_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .temperature (temperature),
    .heating     (heating),
    .cooling     (cooling),
    .state       (state),
    .lockout     (lockout)
  );

  always #5 clk = ~clk;

  // Mutual exclusion checked on every cycle of the sweep.
  always @(negedge clk) begin
    if (sweep_on) begin
      total++;
      if (heating && cooling) begin
        bad++;
        $display("FAIL both_on: heating=%b cooling=%b want not both 1 at %0t", heating, cooling, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b1;
    temperature = 5'd20;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst = 1'b1;
    enable = 1'b1;
    temperature = 5'd16;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {state, heating, cooling, lockout};
      total++;
      if (obs !== c_S_IDLE) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, c_S_IDLE);
      end
    end
    rst = 1'b0;
    step();
    obs = {state, heating, cooling, lockout};
    total++;
    if (obs !== c_S_HEAT) begin
      bad++;
      $display("FAIL reset_release: got %b want %b", obs, c_S_HEAT);
    end
  endtask

  task automatic test_hysteresis();
    logic [4:0] obs;
    do_reset();
    temperature = 5'd19;
    step();
    obs = {state, heating, cooling, lockout};
    total++;
    if (obs !== c_S_IDLE) begin
      bad++;
      $display("FAIL hyst_19_idle: got %b want %b", obs, c_S_IDLE);
    end
    temperature = 5'd18;
    step();
    obs = {state, heating, cooling, lockout};
    total++;
    if (obs !== c_S_HEAT) begin
      bad++;
      $display("FAIL hyst_18_on: got %b want %b", obs, c_S_HEAT);
    end
    temperature = 5'd19;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {state, heating, cooling, lockout};
      total++;
      if (obs !== c_S_HEAT) begin
        bad++;
        $display("FAIL hyst_19_hold[%0d]: got %b want %b", i, obs, c_S_HEAT);
      end
    end
    temperature = 5'd20;
    step();
    obs = {state, heating, cooling, lockout};
    total++;
    if (obs !== c_S_REST) begin
      bad++;
      $display("FAIL hyst_20_off: got %b want %b", obs, c_S_REST);
    end
  endtask

  task automatic test_min_on();
    logic [4:0] obs;
    do_reset();
    temperature = 5'd16;
    step();
    temperature = 5'd21;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      obs = {state, heating, cooling, lockout};
      total++;
      if (obs !== c_S_HEAT) begin
        bad++;
        $display("FAIL min_on_heat[%0d]: got %b want %b", i, obs, c_S_HEAT);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {state, heating, cooling, lockout};
      total++;
      if (obs !== c_S_REST) begin
        bad++;
        $display("FAIL min_on_rest[%0d]: got %b want %b", i, obs, c_S_REST);
      end
    end
    step();
    obs = {state, heating, cooling, lockout};
    total++;
    if (obs !== c_S_IDLE) begin
      bad++;
      $display("FAIL min_on_idle: got %b want %b", obs, c_S_IDLE);
    end
  endtask

  task automatic test_heat_to_cool();
    logic [4:0] obs;
    logic [4:0] exp_seq [9];
    exp_seq = '{c_S_HEAT, c_S_HEAT, c_S_HEAT, c_S_HEAT,
                c_S_REST, c_S_REST, c_S_REST, c_S_IDLE, c_S_COOL};
    do_reset();
    temperature = 5'd16;
    for (int i = 0; i < 9; i++) begin
      step();
      temperature = 5'd24;
      obs = {state, heating, cooling, lockout};
      total++;
      if (obs !== exp_seq[i] || (heating && cooling)) begin
        bad++;
        $display("FAIL heat_to_cool[%0d]: got %b want %b", i, obs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [4:0] obs;
    logic [4:0] exp_seq [9];
    exp_seq = '{c_S_HEAT, c_S_HEAT, c_S_REST, c_S_REST, c_S_REST,
                c_S_IDLE, c_S_IDLE, c_S_IDLE, c_S_IDLE};
    do_reset();
    temperature = 5'd16;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 1) enable = 1'b0;
      obs = {state, heating, cooling, lockout};
      total++;
      if (obs !== exp_seq[i]) begin
        bad++;
        $display("FAIL enable_drop[%0d]: got %b want %b", i, obs, exp_seq[i]);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_cool();
    logic [4:0] obs;
    do_reset();
    temperature = 5'd24;
    step();
    obs = {state, heating, cooling, lockout};
    total++;
    if (obs !== c_S_COOL) begin
      bad++;
      $display("FAIL cool_enter: got %b want %b", obs, c_S_COOL);
    end
    step();
    rst = 1'b1;
    step();
    obs = {state, heating, cooling, lockout};
    total++;
    if (obs !== c_S_IDLE) begin
      bad++;
      $display("FAIL cool_reset: got %b want %b", obs, c_S_IDLE);
    end
    rst = 1'b0;
    step();
    obs = {state, heating, cooling, lockout};
    total++;
    if (obs !== c_S_COOL) begin
      bad++;
      $display("FAIL cool_after_reset: got %b want %b", obs, c_S_COOL);
    end
  endtask

  task automatic test_sweep();
    int t;
    int dir;
    do_reset();
    t = 16;
    dir = 1;
    sweep_on = 1'b1;
    for (int i = 0; i < 50; i++) begin
      temperature = 5'(t);
      step();
      if (t == 24) dir = -1;
      else if (t == 16) dir = 1;
      t = t + dir;
    end
    sweep_on = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hysteresis();
    test_min_on();
    test_heat_to_cool();
    test_enable_drop();
    test_reset_mid_cool();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
